// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - RAW hazard detection, load-use stall FSM and memory freeze control
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/freeze cycle counters.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          forwarding_mode,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic [REG_ADDR_W-1:0]         exe_dest,
    input  logic                          exe_wb_en,
    input  logic                          exe_mem_read,
    input  logic [REG_ADDR_W-1:0]         mem_dest,
    input  logic                          mem_wb_en,
    input  logic                          mem_req,
    input  logic                          mem_ready,
    output logic                          hazard_detected,
    output logic                          id_ex_bubble,
    output logic                          freeze,
    output logic [1:0]                    stall_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]                   stall_cycles,
    output logic [15:0]                   freeze_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [3:0] LOAD_INIT   = 4'(LOAD_LAT - 1);
    localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       exe_any, mem_any, raw_hazard, mem_stall;
    logic       haz_int, freeze_int;

    always_comb begin
        exe_any = 1'b0;
        mem_any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used[i] && exe_wb_en && (src_addr[i*REG_ADDR_W +: REG_ADDR_W] == exe_dest))
                exe_any = 1'b1;
            if (src_used[i] && mem_wb_en && (src_addr[i*REG_ADDR_W +: REG_ADDR_W] == mem_dest))
                mem_any = 1'b1;
        end
    end

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign raw_hazard = forwarding_mode ? (exe_mem_read & exe_any) : (exe_any | mem_any);
    assign mem_stall  = mem_req & ~mem_ready;

    always_comb begin
        haz_int    = 1'b0;
        freeze_int = 1'b0;
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (mem_stall) begin
                    freeze_int = 1'b1;
                    state_next = MEM_WAIT;
                end else begin
                    haz_int = raw_hazard;
                    if (forwarding_mode && raw_hazard && MULTI_CYCLE) begin
                        cnt_next   = LOAD_INIT;
                        state_next = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                haz_int = 1'b1;
                if (mem_stall) begin
                    freeze_int = 1'b1;
                end else if (cnt == 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) freeze_int = 1'b1;
                else           state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign hazard_detected = haz_int & ~rst;
    assign id_ex_bubble    = haz_int & ~rst;
    assign freeze          = freeze_int & ~rst;
    assign stall_state     = state;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= 16'd0;
            freeze_cycles <= 16'd0;
        end else begin
            if (hazard_detected && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (freeze && (freeze_cycles != 16'hFFFF))
                freeze_cycles <= freeze_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl (LOAD_LAT=3)
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        forwarding_mode;
    logic [11:0] src_addr;
    logic [2:0]  src_used;
    logic [3:0]  exe_dest;
    logic        exe_wb_en;
    logic        exe_mem_read;
    logic [3:0]  mem_dest;
    logic        mem_wb_en;
    logic        mem_req;
    logic        mem_ready;
    logic        hazard_detected;
    logic        id_ex_bubble;
    logic        freeze;
    logic [1:0]  stall_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] freeze_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // {hazard_detected, id_ex_bubble, freeze, stall_state}
    wire [4:0] obs = {hazard_detected, id_ex_bubble, freeze, stall_state};

    hazard_stall_ctrl #(.REG_ADDR_W(4), .NUM_SRC(3), .LOAD_LAT(3)) dut (
        .clk(clk), .rst(rst), .forwarding_mode(forwarding_mode),
        .src_addr(src_addr), .src_used(src_used),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .hazard_detected(hazard_detected), .id_ex_bubble(id_ex_bubble),
        .freeze(freeze), .stall_state(stall_state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        forwarding_mode = 1'b0;
        src_addr = 12'h000; src_used = 3'b000;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        forwarding_mode = 1'b1;
        src_addr = 12'h700; src_used = 3'b100;
        exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        src_addr = 12'h003; src_used = 3'b001; exe_dest = 4'd3; exe_wb_en = 1'b1;
        mem_req = 1'b1;
        #2;
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 5'b00000); end
        step();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL post_reset_idle obs=%b exp=%b", obs, 5'b00000); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL perf_stall_reset got=%h exp=%h", stall_cycles, 16'd0); end
        checks++; if (freeze_cycles !== 16'd0) begin errors++; $display("FAIL perf_freeze_reset got=%h exp=%h", freeze_cycles, 16'd0); end
`endif
        step();
    endtask

    task automatic test_raw_exe();
        clear_inputs();
        src_addr = 12'h003; src_used = 3'b001; exe_dest = 4'd3; exe_wb_en = 1'b1;
        @(negedge clk);
        checks++; if (obs !== 5'b11000) begin errors++; $display("FAIL raw_exe_hit obs=%b exp=%b", obs, 5'b11000); end
        step();
        src_used = 3'b000;
        @(negedge clk);
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL raw_exe_unused obs=%b exp=%b", obs, 5'b00000); end
        step();
        src_used = 3'b001; mem_dest = 4'd3; mem_wb_en = 1'b1;
        @(negedge clk);
        checks++; if (obs !== 5'b11000) begin errors++; $display("FAIL raw_exe_mem_same obs=%b exp=%b", obs, 5'b11000); end
        step();
    endtask

    task automatic test_raw_mem();
        clear_inputs();
        src_addr = 12'h050; src_used = 3'b010; mem_dest = 4'd5; mem_wb_en = 1'b1;
        @(negedge clk);
        checks++; if (obs !== 5'b11000) begin errors++; $display("FAIL raw_mem_nofwd obs=%b exp=%b", obs, 5'b11000); end
        step();
        forwarding_mode = 1'b1;
        @(negedge clk);
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL raw_mem_fwd obs=%b exp=%b", obs, 5'b00000); end
        step();
        exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_read = 1'b0;
        @(negedge clk);
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL fwd_exe_nonload obs=%b exp=%b", obs, 5'b00000); end
        step();
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_load_use();
        @(negedge clk);
        checks++; if (obs !== 5'b11000) begin errors++; $display("FAIL load_use_c1 obs=%b exp=%b", obs, 5'b11000); end
        step();
        clear_inputs();
        forwarding_mode = 1'b0;
        @(negedge clk);
        checks++; if (obs !== 5'b11001) begin errors++; $display("FAIL load_use_c2 obs=%b exp=%b", obs, 5'b11001); end
        step();
        forwarding_mode = 1'b1;
        @(negedge clk);
        checks++; if (obs !== 5'b11001) begin errors++; $display("FAIL load_use_c3 obs=%b exp=%b", obs, 5'b11001); end
        step();
        @(negedge clk);
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL load_use_done obs=%b exp=%b", obs, 5'b00000); end
        step();
        clear_inputs();
    endtask

    task automatic test_load_freeze();
        clear_inputs();
        set_load_use();
        @(negedge clk);
        checks++; if (obs !== 5'b11000) begin errors++; $display("FAIL ldfrz_c1 obs=%b exp=%b", obs, 5'b11000); end
        step();
        clear_inputs();
        mem_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if ({freeze, stall_state} !== 3'b101) begin errors++; $display("FAIL ldfrz_frozen%0d got=%b exp=%b", k, {freeze, stall_state}, 3'b101); end
            step();
        end
        mem_req = 1'b0;
        @(negedge clk);
        checks++; if (obs !== 5'b11001) begin errors++; $display("FAIL ldfrz_c2 obs=%b exp=%b", obs, 5'b11001); end
        step();
        @(negedge clk);
        checks++; if (obs !== 5'b11001) begin errors++; $display("FAIL ldfrz_c3 obs=%b exp=%b", obs, 5'b11001); end
        step();
        @(negedge clk);
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL ldfrz_done obs=%b exp=%b", obs, 5'b00000); end
        step();
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        src_addr = 12'h003; src_used = 3'b001; exe_dest = 4'd3; exe_wb_en = 1'b1;
        mem_req = 1'b1;
        @(negedge clk);
        checks++; if (obs !== 5'b00100) begin errors++; $display("FAIL memwait_c1 obs=%b exp=%b", obs, 5'b00100); end
        step();
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (obs !== 5'b00110) begin errors++; $display("FAIL memwait_c%0d obs=%b exp=%b", k, obs, 5'b00110); end
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (obs !== 5'b00010) begin errors++; $display("FAIL memwait_ready obs=%b exp=%b", obs, 5'b00010); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL memwait_done obs=%b exp=%b", obs, 5'b00000); end
        step();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        set_load_use();
        step();
        @(negedge clk);
        checks++; if (obs !== 5'b11001) begin errors++; $display("FAIL rstmid_pre obs=%b exp=%b", obs, 5'b11001); end
        #1;
        rst = 1'b1;
        mem_req = 1'b1;
        #1;
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL rstmid_async obs=%b exp=%b", obs, 5'b00000); end
        step();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL rstmid_after obs=%b exp=%b", obs, 5'b00000); end
        step();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        clear_inputs();
        src_addr = 12'h003; src_used = 3'b001; exe_dest = 4'd3; exe_wb_en = 1'b1;
        for (int k = 0; k < 3; k++) step();
        clear_inputs();
        @(negedge clk);
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL perf_stall_count got=%h exp=%h", stall_cycles, 16'd3); end
        src_addr = 12'h003; src_used = 3'b001; exe_dest = 4'd3; exe_wb_en = 1'b1;
        for (int k = 0; k < 65540; k++) step();
        @(negedge clk);
        checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL perf_stall_sat got=%h exp=%h", stall_cycles, 16'hFFFF); end
        step();
        clear_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_raw_exe();
        test_raw_mem();
        test_load_use();
        test_load_freeze();
        test_mem_wait();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_reset();
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
